// File: rtl/cs_cmd_seq.sv
// Command sequencer for the control-stream path.
// Waits for FIFO space, accepts a UDP receive request, then walks a chain of
// NSTG stages with one-hot start/done handshakes. Stage 0 runs before the UDP
// receive is released; the remaining stages run afterwards. Each handshake
// state is guarded by a timeout that parks the FSM in ERR with a sticky flag.
//
// state | meaning
// IDLE  | waiting for all FIFO full flags to drop
// WAIT  | FIFO space available, waiting for a UDP receive request
// STG   | stage idx started, waiting for its done
// REL   | UDP receive released, waiting for the request to drop
// DONE  | one-cycle completion, bumps pkt_cnt
// ERR   | a stage or the release timed out, waiting for err_clr or abort
module cs_cmd_seq #(
  parameter int NSTG   = 3,
  parameter int NFIFO  = 3,
  parameter int TO_CYC = 50000,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFIFO-1:0]  fifo_full,
  input  logic              fs_udp_rx,
  output logic              fd_udp_rx,
  output logic [NSTG-1:0]   fs_stg,
  input  logic [NSTG-1:0]   fd_stg,
  input  logic              abort,
  input  logic              err_clr,
  output logic              busy,
  output logic              err,
  output logic [2:0]        err_stg,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        so
);

  typedef enum logic [3:0] {
    S_IDLE = 4'h8,
    S_WAIT = 4'h9,
    S_STG  = 4'hA,
    S_REL  = 4'hB,
    S_DONE = 4'hC,
    S_ERR  = 4'hE
  } state_t;

  localparam logic [2:0]      IDX_LAST = 3'(NSTG - 1);
  localparam bit              TO_EN    = (TO_CYC > 0);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);

  state_t          state, state_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [NSTG-1:0] stg_sel;
  logic            stg_done;
  logic            to_hit;
  logic            any_full;
  logic            err_set;
  logic            err_drop;
  logic            cnt_inc;

  // One-hot decode of the active stage index; done bits of other stages are masked off.
  always_comb begin
    stg_sel = '0;
    for (int i = 0; i < NSTG; i++) begin
      stg_sel[i] = (idx == 3'(i));
    end
  end

  assign stg_done = |(fd_stg & stg_sel);
  assign to_hit   = TO_EN && (to_cnt == TO_LAST);
  assign any_full = |fifo_full;

  // Next-state logic: abort beats completion, completion beats timeout.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_set   = 1'b0;
    err_drop  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!any_full) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (abort || any_full) begin
          state_nxt = S_IDLE;
        end else if (fs_udp_rx) begin
          state_nxt = S_STG;
          idx_nxt   = 3'd0;
        end
      end
      S_STG: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (stg_done) begin
          if (idx == 3'd0) begin
            state_nxt = S_REL;
          end else if (idx == IDX_LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else if (to_hit) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end
      end
      S_REL: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (!fs_udp_rx) begin
          if (NSTG == 1) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_STG;
            idx_nxt   = 3'd1;
          end
        end else if (to_hit) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_inc   = !abort;
      end
      S_ERR: begin
        if (abort || err_clr) begin
          state_nxt = S_IDLE;
          err_drop  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // idx is parked at 0 whenever the sequencer goes back to IDLE
    if (state_nxt == S_IDLE) idx_nxt = 3'd0;
  end

  // Timeout counter restarts on each new handshake (state entry or stage change).
  always_comb begin
    to_cnt_nxt = '0;
    if ((state_nxt == S_STG || state_nxt == S_REL) &&
        (state_nxt != state || idx_nxt != idx)) begin
      to_cnt_nxt = '0;
    end else if (state == S_STG || state == S_REL) begin
      to_cnt_nxt = to_cnt + 1'b1;
    end
  end

  // State, stage index and timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= 3'd0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  // Sticky error flag and failing stage; err_stg survives err_clr for post-mortem.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_stg <= 3'd0;
    end else if (err_set) begin
      err     <= 1'b1;
      err_stg <= (state == S_REL) ? 3'd0 : idx;
    end else if (err_drop) begin
      err     <= 1'b0;
    end
  end

  // Completed-command counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= 16'd0;
    end else if (cnt_inc) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  // Moore output decode from registered state.
  always_comb begin
    fs_stg    = (state == S_STG) ? stg_sel : '0;
    fd_udp_rx = (state == S_REL);
    busy      = (state == S_WAIT) || (state == S_STG) ||
                (state == S_REL)  || (state == S_DONE);
    so        = ~{1'b0, idx, state};
  end

endmodule

// File: tb/tb_cs_cmd_seq.sv
// Bench for cs_cmd_seq: directed scenarios plus randomized traffic, all
// checked against a step-list model of a command kept in the bench.
module tb_cs_cmd_seq;

  localparam int NSTG   = 3;
  localparam int NFIFO  = 3;
  localparam int TO_CYC = 16;
  localparam int TO_W   = 16;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic             clk;
  logic             rst;
  logic [NFIFO-1:0] fifo_full;
  logic             fs_udp_rx;
  logic             fd_udp_rx;
  logic [NSTG-1:0]  fs_stg;
  logic [NSTG-1:0]  fd_stg;
  logic             abort;
  logic             err_clr;
  logic             busy;
  logic             err;
  logic [2:0]       err_stg;
  logic [15:0]      pkt_cnt;
  logic [7:0]       so;

  int checks;
  int failures;

  // model: a command is a list of steps (stage0, release, stage1..NSTG-1)
  int          m_mode;
  int          m_pos;
  int          m_age;
  bit          m_err;
  int          m_err_stg;
  logic [15:0] m_cnt;

  cs_cmd_seq #(.NSTG(NSTG), .NFIFO(NFIFO), .TO_CYC(TO_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .fifo_full(fifo_full), .fs_udp_rx(fs_udp_rx),
    .fd_udp_rx(fd_udp_rx), .fs_stg(fs_stg), .fd_stg(fd_stg), .abort(abort),
    .err_clr(err_clr), .busy(busy), .err(err), .err_stg(err_stg),
    .pkt_cnt(pkt_cnt), .so(so)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // stage number of a step, -1 for the UDP release step
  function automatic int step_stage(input int pos);
    if (pos == 0) return 0;
    if (pos == 1) return -1;
    return pos - 1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_age = 0;
    m_err = 0; m_err_stg = 0; m_cnt = 16'd0;
  endtask

  task automatic model_update();
    int  s;
    bit  done;
    if (abort && m_mode != M_IDLE) begin
      m_mode = M_IDLE;
      m_err  = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (fifo_full == 0) m_mode = M_WAIT;
      M_WAIT: begin
        if (fifo_full != 0) m_mode = M_IDLE;
        else if (fs_udp_rx) begin m_mode = M_RUN; m_pos = 0; m_age = 0; end
      end
      M_RUN: begin
        s = step_stage(m_pos);
        done = (s < 0) ? !fs_udp_rx : fd_stg[s];
        if (done) begin
          m_pos++;
          m_age = 0;
          if (m_pos == NSTG + 1) m_mode = M_DONE;
        end else if (TO_CYC > 0 && m_age == TO_CYC - 1) begin
          m_mode = M_ERR; m_err = 1; m_err_stg = (s < 0) ? 0 : s;
        end else begin
          m_age++;
        end
      end
      M_DONE: begin m_cnt = m_cnt + 16'd1; m_mode = M_IDLE; end
      M_ERR: if (err_clr) begin m_mode = M_IDLE; m_err = 0; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    logic [3:0]      code;
    logic [3:0]      exp_lo;
    logic [3:0]      exp_hi;
    logic [NSTG-1:0] exp_fs;
    int              s;
    exp_fs = '0;
    s = (m_mode == M_RUN) ? step_stage(m_pos) : -1;
    case (m_mode)
      M_IDLE: code = 4'h8;
      M_WAIT: code = 4'h9;
      M_RUN:  code = (s < 0) ? 4'hB : 4'hA;
      M_DONE: code = 4'hC;
      default: code = 4'hE;
    endcase
    if (s >= 0) exp_fs[s] = 1'b1;
    exp_lo = ~code;
    check("so_state", so[3:0], exp_lo);
    check("busy", busy, (m_mode == M_WAIT || m_mode == M_RUN || m_mode == M_DONE));
    check("fd_udp_rx", fd_udp_rx, (m_mode == M_RUN && s < 0));
    check("fs_stg", fs_stg, exp_fs);
    check("err", err, m_err);
    check("err_stg", err_stg, m_err_stg);
    check("pkt_cnt", pkt_cnt, m_cnt);
    if (s >= 0) begin
      exp_hi = ~{1'b0, 3'(s)};
      check("so_idx", so[7:4], exp_hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // full zero-latency command starting from WAIT
  task automatic run_cmd();
    fs_udp_rx = 1; tick();
    fd_stg = 3'b001; tick();
    fd_stg = 3'b000; fs_udp_rx = 0; tick();
    fd_stg = 3'b010; tick();
    fd_stg = 3'b100; tick();
    fd_stg = 3'b000; tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; fifo_full = '0; fs_udp_rx = 0; fd_stg = '0; abort = 0; err_clr = 0;
    model_reset();
    #12;
    check("rst_so", so, 8'hF7);
    compare_all();
    @(negedge clk);
    rst = 0;
    tick();
    check("idle_to_wait", so[3:0], 4'h6);
    check("wait_busy", busy, 1'b1);

    // normal command
    fs_udp_rx = 1; tick();
    check("t_stg0", fs_stg, 3'b001);
    fd_stg = 3'b001; tick();
    check("t_rel", fd_udp_rx, 1'b1);
    fd_stg = 3'b000; fs_udp_rx = 0; tick();
    check("t_stg1", fs_stg, 3'b010);
    fd_stg = 3'b010; tick();
    check("t_stg2", fs_stg, 3'b100);
    fd_stg = 3'b100; tick();
    check("t_done", so[3:0], 4'h3);
    fd_stg = 3'b000; tick();
    check("t_cnt1", pkt_cnt, 16'd1);
    tick();

    // fifo full blocks acceptance
    fifo_full = 3'b010; tick();
    fs_udp_rx = 1; tick();
    fs_udp_rx = 0; tick();
    check("full_idle", so[3:0], 4'h7);
    check("full_cnt", pkt_cnt, 16'd1);
    fifo_full = 3'b000; tick();
    check("full_wait", so[3:0], 4'h6);

    // timeout in stage 2
    fs_udp_rx = 1; tick();
    fd_stg = 3'b001; tick();
    fd_stg = 3'b000; fs_udp_rx = 0; tick();
    fd_stg = 3'b010; tick();
    fd_stg = 3'b000;
    for (int i = 0; i < TO_CYC - 1; i++) tick();
    check("to_pre", fs_stg, 3'b100);
    tick();
    check("to_err", err, 1'b1);
    check("to_stg", err_stg, 3'd2);
    check("to_fs", fs_stg, 3'b000);
    err_clr = 1; tick();
    err_clr = 0;
    check("clr_err", err, 1'b0);
    check("clr_idle", so[3:0], 4'h7);
    check("clr_keep", err_stg, 3'd2);
    tick();

    // abort beats completion in stage 1
    fs_udp_rx = 1; tick();
    fd_stg = 3'b001; tick();
    fd_stg = 3'b000; fs_udp_rx = 0; tick();
    abort = 1; fd_stg = 3'b010; tick();
    abort = 0; fd_stg = 3'b000;
    check("ab_idle", so[3:0], 4'h7);
    check("ab_fs", fs_stg, 3'b000);
    check("ab_cnt", pkt_cnt, 16'd1);
    check("ab_err", err, 1'b0);
    tick();

    // counter wrap
    force dut.pkt_cnt = 16'hFFFF;
    #1;
    release dut.pkt_cnt;
    m_cnt = 16'hFFFF;
    run_cmd();
    check("wrap", pkt_cnt, 16'h0000);
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int fd_pct;
      fd_pct = (((cyc / 300) % 3) == 2) ? 5 : 40;
      fifo_full = ($urandom_range(0, 7) == 0) ? NFIFO'($urandom) : '0;
      fs_udp_rx = ($urandom_range(0, 2) != 0);
      for (int b = 0; b < NSTG; b++) fd_stg[b] = ($urandom_range(0, 99) < fd_pct);
      abort   = ($urandom_range(0, 59) == 0);
      err_clr = ($urandom_range(0, 3) == 0);
      tick();
    end
    fifo_full = '0; fs_udp_rx = 0; fd_stg = '0; abort = 0; err_clr = 0;
    tick();
    tick();

    // asynchronous reset mid-command
    fs_udp_rx = 1; tick();
    fd_stg = 3'b001; tick();
    fd_stg = 3'b000; fs_udp_rx = 0; tick();
    #2;
    rst = 1;
    #1;
    model_reset();
    check("arst_so", so, 8'hF7);
    check("arst_fs", fs_stg, 3'b000);
    compare_all();
    @(negedge clk);
    rst = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
